// File: rtl/bit_serial_addsub.sv
// Bit-serial adder/subtractor: one full adder processes the operands LSB first,
// one bit per clock, producing SUM/CO/Z after WIDTH cycles with a DONE pulse.
module bit_serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  input  logic             CI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CO,
  output logic             Z
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             sum_bit;
  logic             maj;
  logic [WIDTH-1:0] res_shifted;

  assign sum_bit     = a_sh[0] ^ b_sh[0] ^ carry;
  assign maj         = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign res_shifted = {sum_bit, SUM[WIDTH-1:1]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      SUM   <= '0;
      CO    <= 1'b0;
      Z     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          DONE <= 1'b0;
          if (START) begin
            a_sh  <= A;
            b_sh  <= BI ? ~B : B;
            carry <= CI;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= maj;
          SUM   <= res_shifted;
          cnt   <= cnt + CW'(1);
          // CO and Z only update once the final bit lands, so they never reflect partial work.
          if (cnt == LAST) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            CO    <= maj;
            Z     <= ~|res_shifted;
            state <= S_DONE;
          end
        end
        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Self-checking bench for bit_serial_addsub (WIDTH=8): directed scenarios plus
// randomized operations compared against an arithmetic reference model.
module tb_bit_serial_addsub;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         BI = 1'b0;
  logic         CI = 1'b0;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] SUM;
  logic         CO;
  logic         Z;

  int total = 0;
  int bad = 0;

  bit_serial_addsub #(.WIDTH(W)) dut (
    .CLK(CLK), .nRST(nRST), .START(START), .A(A), .B(B), .BI(BI), .CI(CI),
    .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .CO(CO), .Z(Z)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain (WIDTH+1)-bit arithmetic on the operands.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bi, input logic ci);
    logic [W-1:0] bb;
    bb = bi ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
  endfunction

  // Called at a negedge while idle. repulse_at / rst_at index the BUSY cycle (0-based), -1 = none.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input logic ci, input int repulse_at, input int rst_at);
    logic [W:0]   r;
    logic [W-1:0] exp_sum;
    r = ref_add(a, b, bi, ci);
    exp_sum = r[W-1:0];
    START = 1'b1; A = a; B = b; BI = bi; CI = ci;
    @(posedge CLK);
    #1;
    START = 1'b0;
    A = W'($urandom); B = W'($urandom); BI = 1'($urandom); CI = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge CLK);
      if (i == rst_at) begin
        nRST = 1'b0;
        #1;
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_sum", 32'(SUM), 32'd0);
        check("rst_co", 32'(CO), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        for (int k = 0; k < 12; k++) begin
          @(negedge CLK);
          check("abort_done", 32'(DONE), 32'd0);
          check("abort_busy", 32'(BUSY), 32'd0);
        end
        $display("op a=%02h b=%02h bi=%0d ci=%0d aborted by reset at busy cycle %0d", a, b, bi, ci, i);
        return;
      end
      check("run_busy", 32'(BUSY), 32'd1);
      check("run_done", 32'(DONE), 32'd0);
      if (i == repulse_at) begin
        START = 1'b1; A = ~a; B = b + 8'd7; BI = ~bi; CI = ~ci;
        @(posedge CLK);
        #1;
        START = 1'b0;
      end
    end
    @(negedge CLK);
    check("done_pulse", 32'(DONE), 32'd1);
    check("done_busy", 32'(BUSY), 32'd0);
    check("sum", 32'(SUM), 32'(exp_sum));
    check("co", 32'(CO), 32'(r[W]));
    check("z", 32'(Z), 32'(exp_sum == '0));
    $display("op a=%02h b=%02h bi=%0d ci=%0d -> sum=%02h co=%0d z=%0d (exp %02h %0d %0d)",
             a, b, bi, ci, SUM, CO, Z, exp_sum, r[W], exp_sum == '0);
    for (int k = 0; k < 3; k++) begin
      A = W'($urandom); B = W'($urandom);
      @(negedge CLK);
      check("idle_done", 32'(DONE), 32'd0);
      check("idle_busy", 32'(BUSY), 32'd0);
      check("hold_sum", 32'(SUM), 32'(exp_sum));
      check("hold_co", 32'(CO), 32'(r[W]));
      check("hold_z", 32'(Z), 32'(exp_sum == '0));
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_done", 32'(DONE), 32'd0);
    check("reset_sum", 32'(SUM), 32'd0);
    check("reset_co", 32'(CO), 32'd0);
    check("reset_z", 32'(Z), 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, -1, -1);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, -1, -1);
    run_op(8'h10, 8'h01, 1'b1, 1'b1, -1, -1);
    run_op(8'h01, 8'h02, 1'b1, 1'b1, -1, -1);
    run_op(8'h33, 8'h44, 1'b0, 1'b1, 2, -1);
    run_op(8'hA5, 8'h5A, 1'b0, 1'b0, -1, 4);

    // START coincident with the first edge after reset release must be accepted.
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    run_op(8'h80, 8'h80, 1'b0, 1'b0, -1, -1);

    // START held high: back-to-back operations every WIDTH+1 cycles.
    START = 1'b1; A = 8'h01; B = 8'h01; BI = 1'b0; CI = 1'b0;
    @(posedge CLK);
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < W; i++) begin
        @(negedge CLK);
        check("b2b_busy", 32'(BUSY), 32'd1);
        check("b2b_nodone", 32'(DONE), 32'd0);
      end
      @(negedge CLK);
      check("b2b_done", 32'(DONE), 32'd1);
      check("b2b_sum", 32'(SUM), 32'h02);
      $display("b2b op %0d: sum=%02h done=%0d", rep, SUM, DONE);
    end
    START = 1'b0;
    @(negedge CLK);
    check("b2b_idle", 32'(BUSY), 32'd0);

    for (int n = 0; n < 30; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_addsub.md
BIT_SERIAL_ADDSUB -- requirements
Module: bit_serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits; legal range 2..32.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state changes occur on the rising edge.
REQ-003 The block SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port START, input, 1, request to begin an operation.
REQ-005 The block SHALL have port A, input, WIDTH, first operand.
REQ-006 The block SHALL have port B, input, WIDTH, second operand.
REQ-007 The block SHALL have port BI, input, 1, invert B (subtract when combined with CI=1).
REQ-008 The block SHALL have port CI, input, 1, carry into bit 0.
REQ-009 The block SHALL have port BUSY, output, 1, high while bits are being processed.
REQ-010 The block SHALL have port DONE, output, 1, one-cycle pulse marking the result as valid.
REQ-011 The block SHALL have port SUM, output, WIDTH, the result A + (BI ? ~B : B) + CI modulo 2^WIDTH.
REQ-012 The block SHALL have port CO, output, 1, carry out of bit WIDTH-1.
REQ-013 The block SHALL have port Z, output, 1, high when SUM is all zeros.

Function
REQ-014 The block SHALL implement states IDLE, RUN and DONE.
- IDLE -> RUN on START=1.
- RUN -> DONE after WIDTH bit cycles.
- DONE -> RUN on START=1; otherwise DONE -> IDLE.
REQ-015 On the edge accepting START, the block SHALL load:
- A into the operand-A shift register;
- (BI ? ~B : B) into the operand-B shift register;
- CI into the carry flop;
- zero into the bit counter.
REQ-016 In RUN, each edge SHALL process exactly one bit, LSB first, with a single full adder:
- sum bit = a0 ^ b0 ^ c;
- carry flop <= majority(a0, b0, c);
- both operand registers shift right;
- the sum bit shifts into the result register MSB.
REQ-017 The bit counter SHALL increment once per RUN cycle, and RUN SHALL end on the edge that processes bit WIDTH-1.
REQ-018 Latency:
- START is sampled at edge 0;
- BUSY is high after edges 0..WIDTH-1;
- DONE is high for exactly the one cycle following edge WIDTH;
- SUM, CO and Z are valid in that cycle.
REQ-019 SUM, CO and Z SHALL hold their final values from DONE until the next accepted START, and SHALL not change while in IDLE.
REQ-020 START SHALL be ignored while BUSY=1, with no effect on the operation in progress.
REQ-021 START=1 in the DONE cycle SHALL be accepted (back-to-back), giving BUSY=1 and DONE=0 on the next cycle.
REQ-022 CO SHALL equal the carry flop value after bit WIDTH-1 has been processed.
REQ-023 Z SHALL be computed from the completed result register only, and SHALL not be computed from partial results.
REQ-024 While RUN is in progress, SUM SHALL expose the partially shifted result register; consumers SHALL sample SUM only when DONE=1.
REQ-025 Operands SHALL be captured at START, so changes on A, B, BI or CI during RUN SHALL have no effect.

Reset
REQ-026 While nRST=0, the block SHALL asynchronously force:
- state to IDLE;
- BUSY=0, DONE=0;
- SUM=0, CO=0, Z=0;
- counter, carry flop and operand registers to 0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation, and no DONE pulse SHALL follow.
REQ-028 After nRST deasserts, the first START SHALL be accepted on the first rising edge at which nRST=1.

Verification (WIDTH=8)
REQ-029 Scenario: A=0x5A, B=0x3C, BI=0, CI=0, START pulse -> BUSY high for 8 cycles, then DONE pulse with SUM=0x96, CO=0, Z=0.
REQ-030 Scenario: A=0xFF, B=0x01, BI=0, CI=0 -> DONE with SUM=0x00, CO=1, Z=1.
REQ-031 Scenario: A=0x10, B=0x01, BI=1, CI=1 -> DONE with SUM=0x0F, CO=1; then A=0x01, B=0x02, BI=1, CI=1 -> SUM=0xFF, CO=0.
REQ-032 Scenario: START re-pulsed in the 3rd BUSY cycle with different operands -> ignored; the result matches the first operands, and exactly one DONE pulse occurs.
REQ-033 Scenario: nRST low for 1 cycle during the 5th BUSY cycle -> BUSY=0, SUM=0 and CO=0 immediately, and no DONE pulse follows.
REQ-034 Scenario: START held high continuously with A=0x01, B=0x01 -> DONE pulses every 9 cycles, each with SUM=0x02, and BUSY is high on the cycle after every DONE.
